// File: rtl/alu.sv
// Single-cycle RV32-style integer ALU: combinational result and flags,
// plus a registered copy of result/zero/negative with one cycle of latency.
module alu (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] v1,
    input  logic [31:0] v2,
    input  logic [3:0]  fn,
    output logic [31:0] out,
    output logic        zero,
    output logic        negative,
    output logic        carry,
    output logic        overflow,
    output logic [31:0] out_q,
    output logic        zero_q,
    output logic        negative_q
);

    logic [32:0] sum33;
    logic [32:0] diff33;
    logic [4:0]  shamt;
    logic        shift_left;
    logic        shift_fill;
    logic [31:0] v1_rev;
    logic [31:0] shift_src;
    logic [31:0] stage_rev;
    logic [31:0] shift_res;
    logic [31:0] stage [0:5];

    assign sum33  = {1'b0, v1} + {1'b0, v2};
    assign diff33 = {1'b0, v1} - {1'b0, v2};

    // Left shifts reuse the right-shift barrel by bit-reversing in and out.
    assign shamt      = v2[4:0];
    assign shift_left = (fn[2:0] == 3'b001);
    assign shift_fill = (fn == 4'hD) & v1[31];

    for (genvar j = 0; j < 32; j++) begin : g_rev
        assign v1_rev[j]    = v1[31-j];
        assign stage_rev[j] = stage[5][31-j];
    end

    assign shift_src = shift_left ? v1_rev : v1;
    assign stage[0]  = shift_src;

    for (genvar i = 0; i < 5; i++) begin : g_stage
        localparam int S = 1 << i;
        assign stage[i+1] = shamt[i] ? {{S{shift_fill}}, stage[i][31:S]} : stage[i];
    end

    assign shift_res = shift_left ? stage_rev : stage[5];

    always_comb begin
        out      = 32'd0;
        carry    = 1'b0;
        overflow = 1'b0;
        case (fn[2:0])
            3'b000: begin
                if (fn[3]) begin
                    out      = diff33[31:0];
                    carry    = ~diff33[32];
                    overflow = (v1[31] != v2[31]) && (diff33[31] != v1[31]);
                end else begin
                    out      = sum33[31:0];
                    carry    = sum33[32];
                    overflow = (v1[31] == v2[31]) && (sum33[31] != v1[31]);
                end
            end
            3'b001:  out = shift_res;
            3'b010:  out = {31'd0, ($signed(v1) < $signed(v2))};
            3'b011:  out = {31'd0, (v1 < v2)};
            3'b100:  out = v1 ^ v2;
            3'b101:  out = shift_res;
            3'b110:  out = v1 | v2;
            3'b111:  out = v1 & v2;
            default: out = 32'd0;
        endcase
    end

    assign zero     = (out == 32'd0);
    assign negative = out[31];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_q      <= 32'd0;
            zero_q     <= 1'b0;
            negative_q <= 1'b0;
        end else begin
            out_q      <= out;
            zero_q     <= zero;
            negative_q <= negative;
        end
    end

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: directed cases plus random operations compared
// against an arithmetic reference model, including the registered stage and reset.
module tb_alu;

    logic        clk;
    logic        rst;
    logic [31:0] v1;
    logic [31:0] v2;
    logic [3:0]  fn;
    logic [31:0] out;
    logic        zero;
    logic        negative;
    logic        carry;
    logic        overflow;
    logic [31:0] out_q;
    logic        zero_q;
    logic        negative_q;

    int tests_run;
    int tests_failed;

    localparam longint TWO32 = 64'sd4294967296;

    alu dut (
        .clk        (clk),
        .rst        (rst),
        .v1         (v1),
        .v2         (v2),
        .fn         (fn),
        .out        (out),
        .zero       (zero),
        .negative   (negative),
        .carry      (carry),
        .overflow   (overflow),
        .out_q      (out_q),
        .zero_q     (zero_q),
        .negative_q (negative_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %h, expected %h (v1=%h v2=%h fn=%h)", tag, actual, expected, v1, v2, fn);
        end
    endtask

    // Reference computed from the mathematical meaning of each operation.
    function automatic void model(input logic [3:0] f, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output logic c, output logic o);
        longint ua, ub, sa, sb, pw, res, sres;
        int     sh;
        ua = longint'(a);
        ub = longint'(b);
        sa = a[31] ? ua - TWO32 : ua;
        sb = b[31] ? ub - TWO32 : ub;
        sh = int'(ub % 32);
        pw = longint'(1) << sh;
        r  = 32'd0;
        c  = 1'b0;
        o  = 1'b0;
        case (f[2:0])
            3'd0: begin
                if (f[3]) begin
                    res  = ua - ub;
                    c    = (ua >= ub);
                    sres = sa - sb;
                end else begin
                    res  = ua + ub;
                    c    = (res >= TWO32);
                    sres = sa + sb;
                end
                r = res[31:0];
                o = (sres > 64'sd2147483647) || (sres < -64'sd2147483648);
            end
            3'd1: begin
                res = (ua * pw) % TWO32;
                r   = res[31:0];
            end
            3'd2: r = (sa < sb) ? 32'd1 : 32'd0;
            3'd3: r = (ua < ub) ? 32'd1 : 32'd0;
            3'd4: r = a ^ b;
            3'd5: begin
                if (f[3] && sa < 0) res = -((-sa + pw - 1) / pw);
                else                res = ua / pw;
                r = res[31:0];
            end
            3'd6: r = a | b;
            default: r = a & b;
        endcase
    endfunction

    // Drive one operation, check the combinational outputs, then the registered copy.
    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input logic [3:0] f);
        logic [31:0] er;
        logic        ec, eo;
        model(f, a, b, er, ec, eo);
        @(negedge clk);
        v1 = a;
        v2 = b;
        fn = f;
        #1;
        checkOutput("out", out, er);
        checkOutput("zero", 32'(zero), 32'(er == 32'd0));
        checkOutput("negative", 32'(negative), 32'(er[31]));
        checkOutput("carry", 32'(carry), 32'(ec));
        checkOutput("overflow", 32'(overflow), 32'(eo));
        @(posedge clk);
        #1;
        checkOutput("out_q", out_q, er);
        checkOutput("zero_q", 32'(zero_q), 32'(er == 32'd0));
        checkOutput("negative_q", 32'(negative_q), 32'(er[31]));
    endtask

    function automatic logic [31:0] pickOperand();
        logic [31:0] edges [6];
        edges[0] = 32'h0000_0000;
        edges[1] = 32'hFFFF_FFFF;
        edges[2] = 32'h7FFF_FFFF;
        edges[3] = 32'h8000_0000;
        edges[4] = 32'h0000_0001;
        edges[5] = 32'h0000_001F;
        if ($urandom_range(0, 3) == 0) return edges[$urandom_range(0, 5)];
        return $urandom;
    endfunction

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst = 1'b1;
        v1  = 32'd0;
        v2  = 32'd0;
        fn  = 4'h0;
        #1;
        checkOutput("reset out_q", out_q, 32'd0);
        checkOutput("reset zero_q", 32'(zero_q), 32'd0);
        checkOutput("reset negative_q", 32'(negative_q), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Directed cases from the verification list.
        applyStimulus(32'h5555_5555 & 32'h55, 32'h55, 4'h8);
        applyStimulus(32'h7FFF_FFFF, 32'd1, 4'h0);
        applyStimulus(32'hFFFF_FFFF, 32'd1, 4'h2);
        applyStimulus(32'hFFFF_FFFF, 32'd1, 4'h3);
        applyStimulus(32'h8000_0000, 32'h24, 4'h5);
        applyStimulus(32'h8000_0000, 32'h24, 4'hD);
        applyStimulus(32'h8000_0000, 32'h24, 4'h1);
        applyStimulus(32'hF0F0_F0F0, 32'hFF00_FF00, 4'h4);
        applyStimulus(32'hF0F0_F0F0, 32'hFF00_FF00, 4'h6);
        applyStimulus(32'hF0F0_F0F0, 32'hFF00_FF00, 4'h7);
        applyStimulus(32'h8765_4321, 32'hFFFF_FFE0, 4'h1);
        applyStimulus(32'h8765_4321, 32'h0000_001F, 4'hD);
        applyStimulus(32'h8765_4321, 32'h0000_001F, 4'h5);
        applyStimulus(32'h8765_4321, 32'h0000_001F, 4'h9);
        applyStimulus(32'h8000_0000, 32'd1, 4'h8);
        applyStimulus(32'hFFFF_FFFF, 32'd1, 4'h0);
        applyStimulus(32'd5, 32'd7, 4'h0);

        // Asynchronous reset mid-cycle clears only the registered stage.
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("mid rst out_q", out_q, 32'd0);
        checkOutput("mid rst zero_q", 32'(zero_q), 32'd0);
        checkOutput("mid rst negative_q", 32'(negative_q), 32'd0);
        checkOutput("mid rst out", out, 32'd12);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("post rst out_q", out_q, 32'd12);

        for (int i = 0; i < 400; i++) begin
            applyStimulus(pickOperand(), pickOperand(), 4'($urandom_range(0, 15)));
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/alu.md
ALU -- requirements
Module: alu

Interface
REQ-001 Ports SHALL use one clock and a reset that is asynchronous and active-high.
REQ-002 clk  input  1  rising-edge clock for the output register stage.
REQ-003 rst  input  1  asynchronous, active-high reset of the registered outputs.
REQ-004 v1  input  32  operand 1 (rs1 value).
REQ-005 v2  input  32  operand 2 (rs2 value or sign-extended immediate).
REQ-006 fn  input  4  operation select: {alt bit, funct3}.
REQ-007 out  output  32  combinational result.
REQ-008 zero  output  1  combinational, 1 when out == 0.
REQ-009 negative  output  1  combinational, equals out[31].
REQ-010 carry  output  1  combinational carry-out of add, or not-borrow of sub; 0 for other ops.
REQ-011 overflow  output  1  combinational signed overflow of add/sub; 0 for other ops.
REQ-012 out_q  output  32  registered copy of out.
REQ-013 zero_q  output  1  registered copy of zero.
REQ-014 negative_q  output  1  registered copy of negative.

Function
REQ-015 out, zero, negative, carry and overflow SHALL be purely combinational from v1, v2 and fn, and SHALL settle in the same cycle; clk and rst SHALL NOT affect them.
REQ-016 fn=0x0 ADD: out = v1 + v2 mod 2^32; carry = bit 32 of the 33-bit sum.
REQ-017 fn=0x8 SUB: out = v1 - v2 mod 2^32; carry = 1 when v1 >= v2 unsigned.
REQ-018 fn=0x1 and fn=0x9 SLL: out = v1 << v2[4:0]; v2[31:5] SHALL be ignored.
REQ-019 fn=0x2 and fn=0xA SLT: out = 1 when v1 < v2 as signed values, else 0; the upper 31 bits SHALL be 0.
REQ-020 fn=0x3 and fn=0xB SLTU: out = 1 when v1 < v2 as unsigned values, else 0.
REQ-021 fn=0x4 and fn=0xC XOR: out = v1 ^ v2.
REQ-022 fn=0x5 SRL: logical right shift of v1 by v2[4:0], zero fill.
REQ-023 fn=0xD SRA: arithmetic right shift of v1 by v2[4:0], filled with v1[31].
REQ-024 fn=0x6 and fn=0xE OR: out = v1 | v2.
REQ-025 fn=0x7 and fn=0xF AND: out = v1 & v2.
REQ-026 A shift amount of 0 SHALL pass v1 through unchanged; a shift amount of 31 SHALL be fully supported.
REQ-027 overflow SHALL be 1 when the operands have the same sign for ADD, or opposite signs for SUB, and the result sign differs from v1[31].
REQ-028 The shifter SHALL be a single-cycle barrel shifter with no multi-cycle iteration.
REQ-029 On every rising clk edge with rst low, out_q, zero_q and negative_q SHALL capture out, zero and negative, giving exactly 1 cycle of latency.
REQ-030 The ALU SHALL have no handshake and no busy state; a new operation SHALL be accepted every cycle.

Reset
REQ-031 While rst is high, out_q SHALL be 0, zero_q SHALL be 0 and negative_q SHALL be 0, immediately and without waiting for clk.
REQ-032 After rst deasserts, the first rising clk edge SHALL load the current combinational result.
REQ-033 An assertion of rst in the middle of operation SHALL clear only the registered outputs; the combinational outputs SHALL continue to track their inputs.

Verification
REQ-034 ADD: v1=5, v2=7, fn=0x0 -> out=12, zero=0, negative=0, carry=0, overflow=0; out_q=12 after the next clk.
REQ-035 SUB and overflow: v1=v2=0x55, fn=0x8 -> out=0, zero=1, carry=1; then v1=0x7FFFFFFF, v2=1, fn=0x0 -> out=0x80000000, negative=1, overflow=1.
REQ-036 Compare: v1=0xFFFFFFFF, v2=1 -> fn=0x2 gives out=1; fn=0x3 gives out=0.
REQ-037 Shifts: v1=0x80000000, v2=0x24 (shift amount 4) -> fn=0x5 gives 0x08000000; fn=0xD gives 0xF8000000; fn=0x1 gives 0.
REQ-038 Logic: v1=0xF0F0F0F0, v2=0xFF00FF00 -> fn=0x4 gives 0x0FF00FF0; fn=0x6 gives 0xFFF0FFF0; fn=0x7 gives 0xF000F000.
REQ-039 Reset: with out_q=12, assert rst between clock edges -> out_q, zero_q and negative_q go to 0 at once while out stays at 12; deassert rst -> the next clk edge restores out_q=12.
